// File: rtl/dm_ctrl_pkg.sv
// Shared types for the data-memory access controller: size codes, FSM states
// and the request-legality rule used at accept time.
package dm_ctrl_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RDW,
        WR,
        RESP
    } state_t;

    // Request attributes captured on accept; the address is kept separately
    // because its width follows the controller parameter.
    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        is_unsigned;
        logic [31:0] wdata;
    } req_attr_t;

    // True for any request that must be answered with an error: halfword on an
    // odd byte, word off a 4-byte boundary, or the reserved size code.
    function automatic logic misaligned(input logic [1:0] size,
                                        input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic is_word_store(input logic we, input logic [1:0] size);
        return we && (size == SZ_WORD);
    endfunction

endpackage

// File: rtl/dm_ctrl_if.sv
// Request/response and memory-side signal bundle of the data-memory controller.
// slave = controller, master = CPU side, mem = the word-wide data memory.
interface dm_ctrl_if #(
    parameter int ADDR_W = 12
);

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;

    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    logic [ADDR_W-3:0] mem_addr;
    logic [31:0]       mem_din;
    logic              mem_we;
    logic [31:0]       mem_dout;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_err,
        output mem_addr, mem_din, mem_we,
        input  mem_dout
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err
    );

    modport mem (
        input  mem_addr, mem_din, mem_we,
        output mem_dout
    );

endinterface

// File: rtl/dm_lane_align.sv
// Byte-lane steering between a 32-bit memory word and right-aligned CPU data:
// extract+extend for loads, lane merge for sub-word stores (little-endian).
module dm_lane_align
    import dm_ctrl_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] store_word
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = word[{addr_lo, 3'b000} +: 8];
    assign half_lane = word[{addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it
        // unassigned -- otherwise synthesis infers a latch.
        load_val   = '0;
        store_word = word;
        case (size)
            SZ_BYTE: begin
                load_val = {{24{~is_unsigned & byte_lane[7]}}, byte_lane};
                store_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                load_val = {{16{~is_unsigned & half_lane[15]}}, half_lane};
                store_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            end
            SZ_WORD: begin
                load_val   = word;
                store_word = wdata;
            end
            default: begin
                load_val   = '0;
                store_word = word;
            end
        endcase
    end

endmodule

// File: rtl/dm_ctrl.sv
// Load/store sequencer for a single-port, word-only, registered-read data memory.
// Sub-word loads extract from the read word; sub-word stores do read-modify-write.
module dm_ctrl
    import dm_ctrl_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic     clk,
    input  logic     rst_n,
    dm_ctrl_if.slave bus
);

    state_t            state;
    state_t            next_state;

    req_attr_t         lat_req;
    logic [ADDR_W-1:0] lat_addr;

    logic              accept;
    logic              req_bad;
    logic              req_word_store;

    logic [31:0]       load_val;
    logic [31:0]       store_word;

    logic [31:0]       resp_rdata_q;
    logic              resp_err_q;
    logic [31:0]       mem_din_q;

    logic              ready_c;
    logic              resp_valid_c;
    logic              mem_we_c;

    assign accept         = bus.req_valid && (state == IDLE);
    assign req_bad        = misaligned(bus.req_size, bus.req_addr[1:0]);
    assign req_word_store = is_word_store(bus.req_we, bus.req_size);

    dm_lane_align u_align (
        .word        (bus.mem_dout),
        .addr_lo     (lat_addr[1:0]),
        .size        (lat_req.size),
        .is_unsigned (lat_req.is_unsigned),
        .wdata       (lat_req.wdata),
        .load_val    (load_val),
        .store_word  (store_word)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_bad)             next_state = RESP;
                    else if (req_word_store) next_state = WR;
                    else                     next_state = RD;
                end
            end
            RD:      next_state = RDW;
            RDW:     next_state = lat_req.we ? WR : RESP;
            WR:      next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Strobes decode straight from the state so an async reset drops them at once.
    always_comb begin
        ready_c      = 1'b0;
        resp_valid_c = 1'b0;
        mem_we_c     = 1'b0;
        case (state)
            IDLE:    ready_c      = 1'b1;
            WR:      mem_we_c     = 1'b1;
            RESP:    resp_valid_c = 1'b1;
            default: ;
        endcase
    end

    // Request latch and result registers; response fields only change on the
    // edge that enters RESP, so they hold steady between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_req      <= '0;
            lat_addr     <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            mem_din_q    <= '0;
        end else begin
            if (accept) begin
                lat_req.we          <= bus.req_we;
                lat_req.size        <= bus.req_size;
                lat_req.is_unsigned <= bus.req_unsigned;
                lat_req.wdata       <= bus.req_wdata;
                lat_addr            <= bus.req_addr;
                if (req_word_store && !req_bad) begin
                    mem_din_q <= bus.req_wdata;
                end
                if (req_bad) begin
                    resp_rdata_q <= '0;
                    resp_err_q   <= 1'b1;
                end
            end
            case (state)
                RDW: begin
                    if (lat_req.we) begin
                        mem_din_q <= store_word;
                    end else begin
                        resp_rdata_q <= load_val;
                        resp_err_q   <= 1'b0;
                    end
                end
                WR: begin
                    resp_rdata_q <= '0;
                    resp_err_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready  = ready_c;
    assign bus.resp_valid = resp_valid_c;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.mem_we     = mem_we_c;
    assign bus.mem_addr   = lat_addr[ADDR_W-1:2];
    assign bus.mem_din    = mem_din_q;

endmodule

// File: tb/tb_dm_ctrl.sv
// Bench for dm_ctrl: directed scenarios with literal expectations plus a random
// sequence scored against a byte-lane arithmetic model of a 1024-word memory.
module tb_dm_ctrl;
    import dm_ctrl_pkg::*;

    localparam int ADDR_W = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dm_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    dm_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Single-port memory: a write cycle blocks the read, read data is registered.
    logic [31:0] mem [1024] = '{default: '0};
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_din;
        else            bus.mem_dout      <= mem[bus.mem_addr];
    end

    int                we_cycles   = 0;
    int                resp_pulses = 0;
    logic [ADDR_W-3:0] last_waddr  = '0;
    logic [31:0]       last_wdin   = '0;
    always @(negedge clk) begin
        if (bus.mem_we) begin
            we_cycles++;
            last_waddr = bus.mem_addr;
            last_wdin  = bus.mem_din;
        end
        if (bus.resp_valid) resp_pulses++;
    end

    logic [31:0] ref_mem [1024] = '{default: '0};
    int tests = 0;
    int fails = 0;

    // Model: every access is a contiguous lane of 1, 2 or 4 bytes at byte offset addr%4.
    task automatic model_req(input logic we, input logic [1:0] size, input logic uns,
                             input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                             output int lat, output logic [31:0] rdata, output logic err);
        int a, off, widx, nbytes;
        logic [31:0] mask, top, v;
        a    = int'(addr);
        off  = a % 4;
        widx = a / 4;
        nbytes = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        err  = (size == 2'b11) || (off % nbytes != 0);
        rdata = '0;
        if (err) begin
            lat = 1;
        end else begin
            mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
            if (we) begin
                ref_mem[widx] = (ref_mem[widx] & ~(mask << (8 * off))) | ((wdata & mask) << (8 * off));
                lat = (nbytes == 4) ? 2 : 4;
            end else begin
                v   = (ref_mem[widx] >> (8 * off)) & mask;
                top = (mask >> 1) + 32'd1;
                if (!uns && (v & top) != 0) v = v | ~mask;
                rdata = v;
                lat = 3;
            end
        end
    endtask

    // Issues one request from IDLE and waits (bounded) for its response.
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                          output int lat, output logic [31:0] rdata, output logic err,
                          output logic pulse_one, output int exp_lat,
                          output logic [31:0] exp_rdata, output logic exp_err);
        model_req(we, size, uns, addr, wdata, exp_lat, exp_rdata, exp_err);
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        @(posedge clk);
        lat = -1; rdata = '0; err = 1'b0; pulse_one = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (n == 1) bus.req_valid = 1'b0;
            if (bus.resp_valid) begin
                lat = n; rdata = bus.resp_rdata; err = bus.resp_err;
                break;
            end
        end
        if (lat > 0) begin
            @(negedge clk);
            pulse_one = !bus.resp_valid && bus.req_ready;
        end
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = SZ_WORD;
        bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        rst_n = 1'b0;
        #1;
        tests++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.mem_we !== 1'b0) begin
            fails++;
            $display("FAIL reset_strobes: got ready=%b valid=%b we=%b expected 1 0 0",
                     bus.req_ready, bus.resp_valid, bus.mem_we);
        end
        tests++;
        if (bus.resp_rdata !== 32'h0 || bus.resp_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_resp: got rdata=%h err=%b expected 0 0", bus.resp_rdata, bus.resp_err);
        end
        tests++;
        if (bus.mem_addr !== '0 || bus.mem_din !== 32'h0) begin
            fails++;
            $display("FAIL reset_mem: got addr=%h din=%h expected 0 0", bus.mem_addr, bus.mem_din);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (bus.req_ready !== 1'b1 || resp_pulses !== 0) begin
            fails++;
            $display("FAIL reset_idle: got ready=%b pulses=%0d expected 1 0", bus.req_ready, resp_pulses);
        end
    endtask

    task automatic test_word_store_load();
        int lat, el, w0; logic [31:0] rd, er_d; logic er, p1, ee;
        w0 = we_cycles;
        do_req(1'b1, SZ_WORD, 1'b0, 12'h010, 32'hDEAD_BEEF, lat, rd, er, p1, el, er_d, ee);
        tests++;
        if (lat !== 2 || er !== 1'b0 || rd !== 32'h0 || p1 !== 1'b1) begin
            fails++;
            $display("FAIL sw_resp: got lat=%0d err=%b rdata=%h pulse1=%b expected 2 0 0 1", lat, er, rd, p1);
        end
        tests++;
        if (we_cycles - w0 !== 1 || last_waddr !== 10'd4 || last_wdin !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL sw_write: got writes=%0d addr=%h din=%h expected 1 004 deadbeef",
                     we_cycles - w0, last_waddr, last_wdin);
        end
        do_req(1'b0, SZ_WORD, 1'b0, 12'h010, 32'h0, lat, rd, er, p1, el, er_d, ee);
        tests++;
        if (lat !== 3 || er !== 1'b0 || rd !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL lw_resp: got lat=%0d err=%b rdata=%h expected 3 0 deadbeef", lat, er, rd);
        end
    endtask

    task automatic test_subword_load();
        logic [ADDR_W-1:0] addrs [4] = '{12'h013, 12'h013, 12'h012, 12'h012};
        logic [1:0]        sizes [4] = '{SZ_BYTE, SZ_BYTE, SZ_BYTE, SZ_HALF};
        logic              unss  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0]       exps  [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_FFFF, 32'h0000_80FF};
        int lat, el; logic [31:0] rd, er_d; logic er, p1, ee;
        do_req(1'b1, SZ_WORD, 1'b0, 12'h010, 32'h80FF_7F01, lat, rd, er, p1, el, er_d, ee);
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, sizes[i], unss[i], addrs[i], 32'h0, lat, rd, er, p1, el, er_d, ee);
            tests++;
            if (lat !== 3 || er !== 1'b0 || rd !== exps[i]) begin
                fails++;
                $display("FAIL subload_%0d: got lat=%0d err=%b rdata=%h expected 3 0 %h",
                         i, lat, er, rd, exps[i]);
            end
        end
    endtask

    task automatic test_rmw_store();
        int lat, el; logic [31:0] rd, er_d; logic er, p1, ee;
        do_req(1'b1, SZ_WORD, 1'b0, 12'h010, 32'h1122_3344, lat, rd, er, p1, el, er_d, ee);
        do_req(1'b1, SZ_BYTE, 1'b0, 12'h011, 32'h0000_00AB, lat, rd, er, p1, el, er_d, ee);
        tests++;
        if (lat !== 4 || er !== 1'b0 || last_wdin !== 32'h1122_AB44 || last_waddr !== 10'd4) begin
            fails++;
            $display("FAIL sb_rmw: got lat=%0d err=%b din=%h addr=%h expected 4 0 1122ab44 004",
                     lat, er, last_wdin, last_waddr);
        end
        do_req(1'b1, SZ_HALF, 1'b0, 12'h012, 32'h0000_CDEF, lat, rd, er, p1, el, er_d, ee);
        tests++;
        if (lat !== 4 || er !== 1'b0 || last_wdin !== 32'hCDEF_AB44) begin
            fails++;
            $display("FAIL sh_rmw: got lat=%0d err=%b din=%h expected 4 0 cdefab44", lat, er, last_wdin);
        end
        do_req(1'b0, SZ_WORD, 1'b0, 12'h010, 32'h0, lat, rd, er, p1, el, er_d, ee);
        tests++;
        if (rd !== 32'hCDEF_AB44) begin
            fails++;
            $display("FAIL rmw_readback: got %h expected cdefab44", rd);
        end
    endtask

    task automatic test_errors();
        logic              wes   [3] = '{1'b1, 1'b0, 1'b0};
        logic [1:0]        sizes [3] = '{SZ_HALF, SZ_WORD, SZ_ILLEGAL};
        logic [ADDR_W-1:0] addrs [3] = '{12'h001, 12'h006, 12'h010};
        int lat, el, w0; logic [31:0] rd, er_d; logic er, p1, ee;
        w0 = we_cycles;
        for (int i = 0; i < 3; i++) begin
            do_req(wes[i], sizes[i], 1'b0, addrs[i], 32'h5555_AAAA, lat, rd, er, p1, el, er_d, ee);
            tests++;
            if (lat !== 1 || er !== 1'b1 || rd !== 32'h0) begin
                fails++;
                $display("FAIL err_%0d: got lat=%0d err=%b rdata=%h expected 1 1 0", i, lat, er, rd);
            end
        end
        tests++;
        if (we_cycles !== w0) begin
            fails++;
            $display("FAIL err_nowrite: got %0d write cycles expected 0", we_cycles - w0);
        end
    endtask

    task automatic test_busy_ignored();
        int lat, el, w0, p0; logic [31:0] rd, er_d; logic er, p1, ee;
        logic ready_seen;
        do_req(1'b1, SZ_WORD, 1'b0, 12'h020, 32'h55AA_1234, lat, rd, er, p1, el, er_d, ee);
        w0 = we_cycles; p0 = resp_pulses; ready_seen = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = SZ_WORD; bus.req_addr = 12'h020;
        @(posedge clk);
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            if (bus.req_ready) ready_seen = 1'b1;
            if (n == 3) begin
                tests++;
                if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h55AA_1234) begin
                    fails++;
                    $display("FAIL busy_resp: got valid=%b rdata=%h expected 1 55aa1234",
                             bus.resp_valid, bus.resp_rdata);
                end
                bus.req_valid = 1'b0;
            end else begin
                bus.req_we = 1'b1; bus.req_wdata = 32'hFFFF_FFFF;
                bus.req_addr = (n == 1) ? 12'h030 : 12'h040;
            end
        end
        @(negedge clk);
        tests++;
        if (ready_seen !== 1'b0 || bus.req_ready !== 1'b1) begin
            fails++;
            $display("FAIL busy_ready: got ready_while_busy=%b ready_after=%b expected 0 1",
                     ready_seen, bus.req_ready);
        end
        tests++;
        if (we_cycles !== w0 || resp_pulses - p0 !== 1) begin
            fails++;
            $display("FAIL busy_single: got writes=%0d resps=%0d expected 0 1", we_cycles - w0, resp_pulses - p0);
        end
    endtask

    task automatic test_reset_abort();
        int lat, el, w0, p0; logic [31:0] rd, er_d; logic er, p1, ee;
        w0 = we_cycles; p0 = resp_pulses;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = SZ_BYTE;
        bus.req_addr = 12'h011; bus.req_wdata = 32'h0000_005A;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if (bus.req_ready !== 1'b1 || bus.mem_we !== 1'b0 || bus.resp_valid !== 1'b0) begin
            fails++;
            $display("FAIL abort_now: got ready=%b we=%b valid=%b expected 1 0 0",
                     bus.req_ready, bus.mem_we, bus.resp_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        tests++;
        if (we_cycles !== w0 || resp_pulses !== p0 || bus.resp_rdata !== 32'h0) begin
            fails++;
            $display("FAIL abort_quiet: got writes=%0d resps=%0d rdata=%h expected 0 0 0",
                     we_cycles - w0, resp_pulses - p0, bus.resp_rdata);
        end
        do_req(1'b0, SZ_WORD, 1'b0, 12'h010, 32'h0, lat, rd, er, p1, el, er_d, ee);
        tests++;
        if (rd !== 32'hCDEF_AB44 || lat !== 3) begin
            fails++;
            $display("FAIL abort_mem: got rdata=%h lat=%0d expected cdefab44 3", rd, lat);
        end
    endtask

    task automatic test_random();
        int lat, el; logic [31:0] rd, erd; logic er, p1, ee;
        logic [ADDR_W-1:0] a;
        for (int i = 0; i < 300; i++) begin
            a = ADDR_W'($urandom_range(0, 63));
            do_req(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, lat, rd, er, p1, el, erd, ee);
            tests++;
            if (lat !== el || er !== ee || rd !== erd || p1 !== 1'b1) begin
                fails++;
                $display("FAIL rand_%0d addr=%h: got lat=%0d err=%b rdata=%h pulse1=%b expected %0d %b %h 1",
                         i, a, lat, er, rd, p1, el, ee, erd);
            end
        end
        for (int w = 0; w < 16; w++) begin
            do_req(1'b0, SZ_WORD, 1'b0, ADDR_W'(w * 4), 32'h0, lat, rd, er, p1, el, erd, ee);
            tests++;
            if (rd !== erd || lat !== 3) begin
                fails++;
                $display("FAIL sweep_%0d: got rdata=%h lat=%0d expected %h 3", w, rd, lat, erd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_word_store_load();
        test_subword_load();
        test_rmw_store();
        test_errors();
        test_busy_ignored();
        test_reset_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached with %0d checks done", tests);
        $fatal(1, "timeout");
    end

endmodule
